// File: rtl/sram_like_resp_if.sv
// sram_like_resp_if: request/response bus between an initiator and the SRAM-like responder.
interface sram_like_resp_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall_in;
    logic        hold_resp;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    modport master (
        output req, wr, size, wstrb, addr, wdata, stall_in, hold_resp,
        input  addr_ok, data_ok, rdata
    );
    modport slave (
        input  req, wr, size, wstrb, addr, wdata, stall_in, hold_resp,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_resp.sv
// sram_like_resp: word-array responder with in-order response queue, fixed latency and backpressure.
module sram_like_resp #(
    parameter int MEM_AW = 10,
    parameter int LAT    = 2,
    parameter int QDEPTH = 4
) (
    input logic            clk,
    input logic            reset,
    sram_like_resp_if.slave bus
);
    localparam int QW = $clog2(QDEPTH);
    localparam int CW = QW + 1;

    logic [31:0]       r_mem [2**MEM_AW];
    logic              r_q_wr [QDEPTH];
    logic [31:0]       r_q_data [QDEPTH];
    logic [3:0]        r_q_cd [QDEPTH];
    logic [QW-1:0]     r_wp, r_rp;
    logic [CW-1:0]     r_count;
    logic              r_data_ok;
    logic [31:0]       r_rdata;
    logic [MEM_AW-1:0] w_idx;
    logic [31:0]       w_word;
    logic              w_hs, w_pop, w_bypass, w_push;
    logic              w_unused;

    assign w_unused     = ^{bus.size, bus.addr[31:MEM_AW+2], bus.addr[1:0]};
    assign w_idx        = bus.addr[MEM_AW+1:2];
    assign w_word       = r_mem[w_idx];
    assign bus.addr_ok  = !reset && bus.req && !bus.stall_in && (r_count < CW'(QDEPTH));
    assign w_hs         = bus.req && bus.addr_ok;
    assign w_pop        = (r_count != 0) && (r_q_cd[r_rp] <= 4'd1) && !bus.hold_resp;
    // LAT=1 cannot be met through the registered queue, so an idle queue answers directly
    assign w_bypass     = (LAT == 1) && w_hs && (r_count == 0) && !bus.hold_resp;
    assign w_push       = w_hs && !w_bypass;
    assign bus.data_ok  = r_data_ok && !reset;
    assign bus.rdata    = reset ? 32'h0 : r_rdata;

    always_ff @(posedge clk) begin
        if (w_hs && bus.wr)
            for (int i = 0; i < 4; i++)
                if (bus.wstrb[i]) r_mem[w_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_count   <= '0;
            r_data_ok <= 1'b0;
            r_rdata   <= 32'h0;
        end else begin
            for (int i = 0; i < QDEPTH; i++)
                r_q_cd[i] <= r_q_cd[i] - {3'b0, r_q_cd[i] != 4'd0};
            // countdown is loaded already stepped once for the push edge itself
            if (w_push) begin
                r_q_wr[r_wp]   <= bus.wr;
                r_q_data[r_wp] <= w_word;
                r_q_cd[r_wp]   <= 4'(LAT - 1);
                r_wp           <= r_wp + 1'b1;
            end
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_count   <= r_count + CW'(w_push) - CW'(w_pop);
            r_data_ok <= w_pop || w_bypass;
            r_rdata   <= w_pop ? (r_q_wr[r_rp] ? 32'h0 : r_q_data[r_rp]) :
                         (w_bypass && !bus.wr) ? w_word : 32'h0;
        end
    end
endmodule

// File: doc/sram_like_resp.md
SRAM_LIKE_RESP -- requirements
Module: sram_like_resp

Interface
REQ-001 SHALL have parameter MEM_AW, default 10, meaning word-address width of the backing array (2^MEM_AW 32-bit words).
REQ-002 SHALL have parameter LAT, default 2, meaning minimum cycles from the addr_ok handshake to data_ok; legal range 1..15.
REQ-003 SHALL have parameter QDEPTH, default 4, meaning the maximum number of outstanding accepted transactions; power of 2, 2..16.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req  in  1  initiator request valid.
REQ-007 wr  in  1  1 = write, 0 = read.
REQ-008 size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
REQ-009 wstrb  in  4  write byte enables; ignored for reads.
REQ-010 addr  in  32  byte address.
REQ-011 wdata  in  32  write data.
REQ-012 addr_ok  out  1  request accepted this cycle.
REQ-013 data_ok  out  1  response for the oldest outstanding transaction, valid this cycle.
REQ-014 rdata  out  32  read data, qualified by data_ok.
REQ-015 stall_in  in  1  forces addr_ok low (bench backpressure).
REQ-016 hold_resp  in  1  blocks response delivery (models slow memory).

Function
REQ-017 addr_ok SHALL be combinational: req && !stall_in && (count < QDEPTH), where count is the number of registered outstanding entries.
REQ-018 A handshake (req && addr_ok) SHALL push one entry {wr, rdata_snapshot, countdown=LAT} into an in-order queue.
REQ-019 Word index SHALL be addr[MEM_AW+1:2]; higher address bits SHALL be ignored (aliasing wrap); addr[1:0] SHALL NOT affect the index.
REQ-020 On a write handshake, each byte lane i with wstrb[i]=1 SHALL be updated in the array in that same cycle; size SHALL NOT alter wstrb.
REQ-021 On a read handshake, the snapshot SHALL be the full array word at the index as it stands before any write in that cycle; only one handshake can occur per cycle.
REQ-022 Each entry's countdown SHALL decrement by 1 per cycle while above 0, independent of hold_resp and queue position.
REQ-023 data_ok SHALL be registered: asserted in cycle t+1 iff, in cycle t, the head entry exists, its countdown is 0 or 1, and hold_resp=0; that entry SHALL be popped at the same edge.
REQ-024 With no hold_resp and no queue wait, data_ok SHALL assert exactly LAT cycles after the handshake cycle.
REQ-025 Responses SHALL be strictly in acceptance order; at most one data_ok per cycle.
REQ-026 rdata SHALL equal the snapshot for reads and 32'h0 for writes when data_ok=1, and SHALL be 32'h0 when data_ok=0.
REQ-027 Writes SHALL receive data_ok like reads.
REQ-028 Simultaneous push and pop SHALL leave count unchanged; the count < QDEPTH test SHALL use the pre-pop count (no same-cycle bypass).
REQ-029 Queue pointers SHALL wrap modulo QDEPTH; count SHALL be log2(QDEPTH)+1 bits wide and never exceed QDEPTH.
REQ-030 hold_resp=1 SHALL stall only delivery; countdowns continue, so the head delivers one cycle after hold_resp drops if already at 0.

Reset
REQ-031 While reset=1: count=0, queue pointers=0, data_ok=0, rdata=0, addr_ok=0 (regardless of req); in-flight transactions SHALL be discarded and never answered.
REQ-032 Array contents SHALL NOT be reset; writes completed before reset SHALL persist.
REQ-033 The first handshake SHALL be possible in the first cycle with reset=0.

Verification
REQ-034 Write 32'hDEADBEEF to 0x1C000010, wstrb=4'hF, then read it back (LAT=2) -> addr_ok each request cycle; data_ok 2 cycles after each handshake; second response rdata=32'hDEADBEEF, first rdata=0.
REQ-035 Word preloaded 32'h11223344 at 0x100; write wstrb=4'b0010, wdata=32'hAABBCCDD; read -> rdata=32'h1122CC44.
REQ-036 hold_resp=1, req=1 for 6 cycles (QDEPTH=4) -> exactly 4 handshakes, addr_ok=0 thereafter; drop hold_resp -> data_ok 4 consecutive cycles in order, addr_ok reasserts the cycle after the first pop.
REQ-037 Back-to-back reads of 0x0, 0x4, 0x8 with stall_in pulsed on the second cycle -> handshakes in cycles 0, 2, 3; data_ok in cycles 2, 4, 5 with matching order.
REQ-038 Read 0x4 issued then write 0x4 next cycle -> read returns the old value, write acknowledged one cycle later.
REQ-039 Reset asserted 1 cycle after 3 reads accepted -> no data_ok during or after reset; count=0; a new read after reset returns the correct array data at LAT.
